// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// The registered sel travels with out so a downstream 2:1 mux switches with the data.
module mux_rr_arbiter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic             v0,
   output logic             r0,
   input  logic [WIDTH-1:0] d1,
   input  logic             v1,
   output logic             r1,
   output logic [WIDTH-1:0] out,
   output logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic             last_reg;
   logic [WIDTH-1:0] out_reg;
   logic             sel_reg;
   logic             load;
   logic             gnt_any;
   logic             gnt_id;
   logic             take;
   logic [1:0]       take_vec;

   always_comb begin
      state_next = state_reg;
      load       = (state_reg == EMPTY) || out_ready;
      gnt_any    = v0 || v1;
      gnt_id     = 1'b0;
      // On a tie the source that did not win last time goes next.
      if (v0 && v1) begin
         gnt_id = ~last_reg;
      end else if (v1) begin
         gnt_id = 1'b1;
      end
      take = rst_n && load && gnt_any;
      r0   = take && !gnt_id;
      r1   = take && gnt_id;
      if (take) begin
         state_next = FULL;
      end else if ((state_reg == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   assign take_vec = {r1, r0};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         out_reg   <= '0;
         sel_reg   <= 1'b0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (take) begin
            out_reg  <= gnt_id ? d1 : d0;
            sel_reg  <= gnt_id;
            last_reg <= gnt_id;
         end
      end
   end

   // Free-running debug grant counters, one per source; wrap silently.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [7:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_reg <= 8'd0;
            end else if (take_vec[gi]) begin
               cnt_reg <= cnt_reg + 8'd1;
            end
         end
      end
   endgenerate

   assign out       = out_reg;
   assign sel       = sel_reg;
   assign out_valid = (state_reg == FULL);
   assign cnt0      = g_cnt[0].cnt_reg;
   assign cnt1      = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected words are queued as they are offered,
// and an independent monitor checks each word as the consumer takes it.
module tb_mux_rr_arbiter;

   typedef struct {
      logic       sel;
      logic [1:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] d0, d1, out;
   logic       v0, v1, r0, r1, sel, out_valid, out_ready;
   logic [7:0] cnt0, cnt1;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mux_rr_arbiter #(.WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .d0(d0), .v0(v0), .r0(r0),
      .d1(d1), .v1(v1), .r1(r1),
      .out(out), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n     = 1'b0;
      v0        = 1'b0;
      v1        = 1'b0;
      out_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // Monitor: every output transfer must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got out=%0h sel=%0h expected none t=%0t", out, sel, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("XFER out=%0h sel=%0h exp_out=%0h exp_sel=%0h t=%0t", out, sel, e.data, e.sel, $time);
            chk("out_data", 32'(out), 32'(e.data));
            chk("out_sel", 32'(sel), 32'(e.sel));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] dv;
      // Reset held for two edges with both sources requesting
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 2'b01; d1 = 2'b10; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_r0", 32'(r0), 0);
      chk("rst_r1", 32'(r1), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out", 32'(out), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_cnt0", 32'(cnt0), 0);
      chk("rst_cnt1", 32'(cnt1), 0);
      step();
      rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;

      // Single source
      v0 = 1'b1; d0 = 2'b10; out_ready = 1'b1;
      sb.push_back('{1'b0, 2'b10});
      @(negedge clk);
      chk("single_r0", 32'(r0), 1);
      chk("single_r1", 32'(r1), 0);
      step();
      v0 = 1'b0;
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_out", 32'(out), 32'(2'b10));
      chk("single_sel", 32'(sel), 0);
      chk("single_cnt0", 32'(cnt0), 1);
      step();
      @(negedge clk);
      chk("single_drain", 32'(out_valid), 0);
      step();

      // Tie fairness from a fresh reset: 0,1,0,1,0,1
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         v0 = 1'b1; v1 = 1'b1; d0 = 2'b01; d1 = 2'b11; out_ready = 1'b1;
         if (i % 2 == 0) sb.push_back('{1'b0, 2'b01});
         else            sb.push_back('{1'b1, 2'b11});
         @(negedge clk);
         chk("tie_r0", 32'(r0), (i % 2 == 0) ? 1 : 0);
         chk("tie_r1", 32'(r1), (i % 2 == 0) ? 0 : 1);
         step();
      end
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      chk("tie_cnt0", 32'(cnt0), 3);
      chk("tie_cnt1", 32'(cnt1), 3);
      step();

      // Backpressure: FULL with sel=1, then three stalled cycles with both valid
      v1 = 1'b1; d1 = 2'b10; out_ready = 1'b0;
      sb.push_back('{1'b1, 2'b10});
      @(negedge clk);
      chk("bp_load_r1", 32'(r1), 1);
      step();
      for (int i = 0; i < 3; i++) begin
         v0 = 1'b1; v1 = 1'b1; d0 = 2'b01; d1 = 2'b11; out_ready = 1'b0;
         @(negedge clk);
         chk("bp_r0", 32'(r0), 0);
         chk("bp_r1", 32'(r1), 0);
         chk("bp_out", 32'(out), 32'(2'b10));
         chk("bp_sel", 32'(sel), 1);
         chk("bp_valid", 32'(out_valid), 1);
         step();
      end
      out_ready = 1'b1;
      sb.push_back('{1'b0, 2'b01});
      @(negedge clk);
      chk("bp_resume_r0", 32'(r0), 1);
      chk("bp_resume_r1", 32'(r1), 0);
      step();
      sb.push_back('{1'b1, 2'b11});
      @(negedge clk);
      chk("bp_next_r1", 32'(r1), 1);
      step();
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      chk("bp_cnt0", 32'(cnt0), 4);
      chk("bp_cnt1", 32'(cnt1), 5);
      step();
      @(negedge clk);
      chk("bp_drain", 32'(out_valid), 0);

      // Pass-through in FULL, then drain
      v0 = 1'b1; d0 = 2'b11; out_ready = 1'b1;
      sb.push_back('{1'b0, 2'b11});
      step();
      d0 = 2'b00;
      sb.push_back('{1'b0, 2'b00});
      @(negedge clk);
      chk("pt_valid_a", 32'(out_valid), 1);
      chk("pt_out_a", 32'(out), 32'(2'b11));
      chk("pt_r0", 32'(r0), 1);
      step();
      v0 = 1'b0;
      @(negedge clk);
      chk("pt_valid_b", 32'(out_valid), 1);
      chk("pt_out_b", 32'(out), 32'(2'b00));
      step();
      @(negedge clk);
      chk("pt_drained", 32'(out_valid), 0);
      chk("pt_out_hold", 32'(out), 32'(2'b00));
      chk("pt_cnt0", 32'(cnt0), 6);
      step();

      // 256 grants to source 0 wrap cnt0
      pulse_reset();
      for (int i = 0; i < 256; i++) begin
         dv = i[1:0];
         v0 = 1'b1; d0 = dv; out_ready = 1'b1;
         sb.push_back('{1'b0, dv});
         @(negedge clk);
         chk("wrap_r0", 32'(r0), 1);
         if (i == 255) chk("wrap_cnt0_255", 32'(cnt0), 255);
         step();
      end
      v0 = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("wrap_cnt0", 32'(cnt0), 0);
      chk("wrap_full", 32'(out_valid), 1);
      chk("wrap_out", 32'(out), 32'(2'b11));
      chk("wrap_pending", 32'(sb.size()), 1);
      step();

      // Mid-operation reset discards the held word
      if (sb.size() > 0) sb.delete(0);
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_r0", 32'(r0), 0);
      chk("midrst_r1", 32'(r1), 0);
      step();
      rst_n = 1'b1; d0 = 2'b10; d1 = 2'b01;
      sb.push_back('{1'b0, 2'b10});
      @(negedge clk);
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_cnt0", 32'(cnt0), 0);
      chk("midrst_tie_r0", 32'(r0), 1);
      chk("midrst_tie_r1", 32'(r1), 0);
      step();
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 1);
      chk("midrst_sel", 32'(sel), 0);
      step();
      step();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-source round-robin arbiter with valid/ready handshakes that sits directly upstream of the 2:1 multiplexers. It chooses which of two producers is served next and issues the select as a registered `sel`. It also captures the selected word in a one-entry output register, so the downstream consumer sees a registered `out`/`sel` pair. Fairness is enforced by a last-granted pointer, and per-source 8-bit grant counters support debug.

## Interface
Parameters:
- `WIDTH`, default 2: data width of `d0`, `d1` and `out`; legal range 1..32.

Ports (clock and reset first):
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low; sampled only on the rising edge of `clk`.
- `d0`  input  WIDTH  source 0 data.
- `v0`  input  1  source 0 valid.
- `r0`  output  1  source 0 ready; combinational.
- `d1`  input  WIDTH  source 1 data.
- `v1`  input  1  source 1 valid.
- `r1`  output  1  source 1 ready; combinational.
- `out`  output  WIDTH  registered data of the granted source.
- `sel`  output  1  registered id of the source that supplied `out` (0 = `d0`, 1 = `d1`).
- `out_valid`  output  1  the output register holds a word.
- `out_ready`  input  1  consumer accepts `out` on this cycle.
- `cnt0`  output  8  number of grants to source 0; wraps 255 -> 0.
- `cnt1`  output  8  number of grants to source 1; wraps 255 -> 0.

## Operation
- Transfers:
  - An input transfer occurs on a cycle where `vN && rN`.
  - An output transfer occurs on a cycle where `out_valid && out_ready`.
- State machine, encoded by `out_valid`:
  - EMPTY (`out_valid` = 0): load is enabled.
  - FULL (`out_valid` = 1): load is enabled only when `out_ready` = 1 on that cycle (pass-through at full rate).
- Load enable: `load = !out_valid || out_ready`.
- Grant:
  - Only `v0` set -> grant source 0.
  - Only `v1` set -> grant source 1.
  - Both set -> grant the source that is not `last`.
  - Neither set -> no grant.
- Ready outputs: `r0 = load && grant==0 && v0`; `r1 = load && grant==1 && v1`. At most one is high in any cycle.
- On an input transfer:
  - `out` <= granted data; `sel` <= grant id; `out_valid` <= 1.
  - `last` <= grant id; the matching counter increments.
- Output transfer with no input transfer: `out_valid` <= 0. `out` and `sel` hold their last values.
- Neither transfer occurring: all registers hold.
- `rN` depends on `vN` and `out_ready` combinationally, but a source must not make `vN` depend on `rN`.
- Sources must hold `dN`/`vN` stable until their transfer completes. The arbiter does not check this.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `out` = 0, `sel` = 0, `out_valid` = 0, `cnt0` = 0, `cnt1` = 0.
  - Internal `last` = 1, so source 0 wins the first tie.
- While `rst_n` = 0: `r0` and `r1` are forced to 0 and no transfer is counted.
- Reset mid-operation discards any word in the output register; no output transfer occurs on that edge.
- Latency: an input transfer at edge k gives `out_valid` = 1 with that data and `sel` after edge k, one cycle.
- Throughput: one word per cycle while `out_ready` is held at 1.
- Backpressure:
  - FULL with `out_ready` = 0 -> `r0` = `r1` = 0.
  - `out`, `sel` and the counters hold.
  - `last` is unchanged, so arbitration order resumes exactly when the stall ends.
- Simultaneous output and input transfer in FULL: the register is replaced by the new word and `out_valid` stays 1, with no bubble.
- Counter wrap: 255 + 1 -> 0, with no saturation and no flag.
- `sel` is registered with `out`, so a downstream 2:1 mux fed by `sel` switches on the same edge that the data updates.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `v0` = `v1` = 1.
  - -> `r0` = `r1` = 0, `out_valid` = 0, `out` = 2'b00, `cnt0` = `cnt1` = 0.
- Single source: `v0` = 1, `d0` = 2'b10, `out_ready` = 1 after reset.
  - -> `r0` = 1 on cycle 0; `out` = 2'b10, `sel` = 0, `out_valid` = 1 on cycle 1; `cnt0` = 1.
- Tie fairness: `v0` = `v1` = 1, `d0` = 2'b01, `d1` = 2'b11, `out_ready` = 1 for 6 cycles.
  - -> `sel` sequence 0,1,0,1,0,1; `out` alternates 01/11; `cnt0` = `cnt1` = 3.
- Backpressure: FULL with `sel` = 1, then `out_ready` = 0 for 3 cycles with both valid.
  - -> `r0` = `r1` = 0; `out`/`sel` hold; first grant after the stall is source 0.
- Pass-through vs drain: FULL, `out_ready` = 1, `v0` = 1 -> `out_valid` stays 1 and `out` updates. Next cycle, no valid -> `out_valid` = 0 one cycle later.
- Wrap and mid-reset: 256 grants to source 0 -> `cnt0` = 0. Then `rst_n` pulsed low while FULL -> `out_valid` = 0 and the next tie grants source 0.
